// File: rtl/whack_vga_pkg.sv
// Shared VGA timing, frame-buffer geometry and the plot-address helper
// for the plot-stream sink.
package whack_vga_pkg;

  localparam int COLOUR_W = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_DEPTH = SCREEN_W * SCREEN_H;
  localparam int ADDR_W   = 15;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] H_TOTAL      = H_SYNC_END + H_BACK;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [9:0] V_TOTAL      = V_SYNC_END + V_BACK;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank_n;
    logic frame_start;
  } scan_ctl_t;

  localparam scan_ctl_t CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0, frame_start: 1'b0};

  // y*160 + x without a multiplier: 160 = 128 + 32.
  function automatic logic [ADDR_W-1:0] plot_addr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] yw;
    yw = {8'd0, y};
    return (yw << 7) + (yw << 5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/plot_framebuffer.sv
// 19200x3 simple dual-port frame buffer: one write port, one registered
// read port returning the old word when both ports hit the same address.
module plot_framebuffer
  import whack_vga_pkg::*;
(
  input  logic                iClock,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [COLOUR_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [COLOUR_W-1:0] rd_data
);

  logic [COLOUR_W-1:0] mem [FB_DEPTH];

  always_ff @(posedge iClock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_plot_sink.sv
// Plot-stream sink: stores 160x120 plots and scans them out as 640x480@60
// VGA with 4x4 pixel replication and a 2-cycle counter-to-pin latency.
module vga_plot_sink
  import whack_vga_pkg::*;
#(
  parameter int X_SCREEN_PIXELS = SCREEN_W,
  parameter int Y_SCREEN_PIXELS = SCREEN_H,
  parameter int SCALE_SHIFT     = 2
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic [7:0] iX,
  input  logic [6:0] iY,
  input  logic [2:0] iColour,
  input  logic       iPlot,
  output logic       oHS,
  output logic       oVS,
  output logic       oBlank_n,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB,
  output logic       oFrameStart,
  output logic       oDropped
);

  localparam logic [7:0] X_LIM = 8'(X_SCREEN_PIXELS);
  localparam logic [6:0] Y_LIM = 7'(Y_SCREEN_PIXELS);

  logic [9:0]          hcnt, vcnt;
  logic                visible;
  logic                in_range, wr_en;
  logic [ADDR_W-1:0]   wr_addr, rd_addr, rd_addr_q;
  logic [COLOUR_W-1:0] rd_data;
  scan_ctl_t           ctl_now, ctl_d1, ctl_d2;

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_TOTAL - 10'd1) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_TOTAL - 10'd1) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  assign visible  = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE);
  assign in_range = (iX < X_LIM) && (iY < Y_LIM);
  assign wr_en    = iResetn && iPlot && in_range;
  assign wr_addr  = plot_addr(iX, iY);

  // Outside the visible area the read address is parked on its last value.
  always_comb begin
    rd_addr = rd_addr_q;
    if (visible) rd_addr = plot_addr(8'(hcnt >> SCALE_SHIFT), 7'(vcnt >> SCALE_SHIFT));
  end

  always_comb begin
    ctl_now             = CTL_IDLE;
    ctl_now.hs_n        = !((hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END));
    ctl_now.vs_n        = !((vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END));
    ctl_now.blank_n     = visible;
    ctl_now.frame_start = (hcnt == 10'd0) && (vcnt == 10'd0);
  end

  plot_framebuffer u_fb (
    .iClock  (iClock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (iColour),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Stage 1 lines up with the RAM read, stage 2 with the colour register.
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      rd_addr_q <= '0;
      ctl_d1    <= CTL_IDLE;
      ctl_d2    <= CTL_IDLE;
      oR        <= 8'h00;
      oG        <= 8'h00;
      oB        <= 8'h00;
      oDropped  <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr;
      ctl_d1    <= ctl_now;
      ctl_d2    <= ctl_d1;
      oR        <= ctl_d1.blank_n ? {8{rd_data[2]}} : 8'h00;
      oG        <= ctl_d1.blank_n ? {8{rd_data[1]}} : 8'h00;
      oB        <= ctl_d1.blank_n ? {8{rd_data[0]}} : 8'h00;
      oDropped  <= iPlot && !in_range;
    end
  end

  assign oHS         = ctl_d2.hs_n;
  assign oVS         = ctl_d2.vs_n;
  assign oBlank_n    = ctl_d2.blank_n;
  assign oFrameStart = ctl_d2.frame_start;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Self-checking bench for vga_plot_sink: behavioural scan/frame-buffer model
// compared every cycle, plus literal pixel, sync and drop expectations.
module tb_vga_plot_sink;

  logic       iClock = 1'b0;
  logic       iResetn = 1'b0;
  logic [7:0] iX = '0;
  logic [6:0] iY = '0;
  logic [2:0] iColour = '0;
  logic       iPlot = 1'b0;
  logic       oHS, oVS, oBlank_n, oFrameStart, oDropped;
  logic [7:0] oR, oG, oB;

  int total = 0;
  int bad   = 0;

  vga_plot_sink dut (
    .iClock      (iClock),
    .iResetn     (iResetn),
    .iX          (iX),
    .iY          (iY),
    .iColour     (iColour),
    .iPlot       (iPlot),
    .oHS         (oHS),
    .oVS         (oVS),
    .oBlank_n    (oBlank_n),
    .oR          (oR),
    .oG          (oG),
    .oB          (oB),
    .oFrameStart (oFrameStart),
    .oDropped    (oDropped)
  );

  always #20 iClock = ~iClock;

  // Reference model: k counts clock edges since reset release, so the scan
  // position on the pins after edge k is k-2 and the frame buffer is read
  // for position k-1 before that edge's write lands.
  logic [2:0] fb [19200];
  bit         fb_known [19200];
  int         k = 0;
  int         m_p, m_h, m_v, m_a;
  logic [2:0] snap = '0;
  bit         snap_known = 1'b0;
  bit         exp_hs = 1'b1, exp_vs = 1'b1, exp_blank = 1'b0, exp_fs = 1'b0, exp_drop = 1'b0;
  logic [2:0] exp_col = '0;
  bit         exp_col_known = 1'b1;
  bit         chk_en = 1'b0;

  always @(posedge iClock) begin
    chk_en = 1'b1;
    if (!iResetn) begin
      k = 0;
      exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0; exp_fs = 1'b0; exp_drop = 1'b0;
      exp_col = '0; exp_col_known = 1'b1;
    end else begin
      k = k + 1;
      if (k >= 2) begin
        m_p = (k - 2) % 420000;
        m_h = m_p % 800;
        m_v = m_p / 800;
        exp_hs    = !(m_h >= 656 && m_h < 752);
        exp_vs    = !(m_v >= 490 && m_v < 492);
        exp_blank = (m_h < 640) && (m_v < 480);
        exp_fs    = (m_p == 0);
        exp_col   = exp_blank ? snap : 3'd0;
        exp_col_known = !exp_blank || snap_known;
      end else begin
        exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0; exp_fs = 1'b0;
        exp_col = '0; exp_col_known = 1'b1;
      end
      m_p = (k - 1) % 420000;
      m_h = m_p % 800;
      m_v = m_p / 800;
      if (m_h < 640 && m_v < 480) begin
        m_a = (m_v / 4) * 160 + (m_h / 4);
        snap = fb[m_a];
        snap_known = fb_known[m_a];
      end
      exp_drop = iPlot && !(iX < 8'd160 && iY < 7'd120);
      if (iPlot && iX < 8'd160 && iY < 7'd120) begin
        m_a = int'(iY) * 160 + int'(iX);
        fb[m_a] = iColour;
        fb_known[m_a] = 1'b1;
      end
    end
  end

  always @(negedge iClock) begin
    logic [23:0] exp_rgb;
    if (chk_en) begin
      exp_rgb = {{8{exp_col[2]}}, {8{exp_col[1]}}, {8{exp_col[0]}}};
      total++;
      if ({oHS, oVS, oBlank_n, oFrameStart, oDropped} !== {exp_hs, exp_vs, exp_blank, exp_fs, exp_drop} ||
          (exp_col_known && {oR, oG, oB} !== exp_rgb)) begin
        bad++;
        $display("[TB] FAIL scan k=%0d got hs/vs/bl/fs/dr=%b rgb=%h required %b rgb=%h",
                 k, {oHS, oVS, oBlank_n, oFrameStart, oDropped}, {oR, oG, oB},
                 {exp_hs, exp_vs, exp_blank, exp_fs, exp_drop}, exp_rgb);
      end
    end
  end

  // Drives one cycle of inputs and returns at the negedge after it is sampled.
  task automatic applyStimulus(input bit rstn, input bit plot, input logic [7:0] x,
                               input logic [6:0] y, input logic [2:0] col);
    iResetn = rstn;
    iPlot   = plot;
    iX      = x;
    iY      = y;
    iColour = col;
    @(posedge iClock);
    @(negedge iClock);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  int hs_low = 0;
  int bl_high = 0;

  initial begin
    logic [7:0] rx;
    logic [6:0] ry;
    @(negedge iClock);
    applyStimulus(1'b0, 1'b1, 8'd5, 7'd5, 3'd7);
    applyStimulus(1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
    checkOutput("reset_state", {oHS, oVS, oBlank_n, oFrameStart, oDropped, oR, oG, oB},
                {5'b11000, 24'h000000});

    applyStimulus(1'b1, 1'b0, 8'd0, 7'd0, 3'd0);
    checkOutput("release_cycle1", {oFrameStart, oBlank_n, oHS}, 3'b001);
    applyStimulus(1'b1, 1'b0, 8'd0, 7'd0, 3'd0);
    checkOutput("first_frame_start", {oFrameStart, oBlank_n}, 2'b11);
    applyStimulus(1'b1, 1'b0, 8'd0, 7'd0, 3'd0);
    checkOutput("frame_start_pulse_end", oFrameStart, 1'b0);

    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        applyStimulus(1'b1, 1'b1, 8'(x), 7'(y), 3'(x + y));

    applyStimulus(1'b1, 1'b1, 8'd0, 7'd0, 3'b100);
    applyStimulus(1'b1, 1'b1, 8'd159, 7'd2, 3'b011);
    applyStimulus(1'b1, 1'b1, 8'd160, 7'd5, 3'd7);
    checkOutput("drop_x", oDropped, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd0, 7'd0, 3'd0);
    checkOutput("drop_pulse_end", oDropped, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'd3, 7'd120, 3'd7);
    checkOutput("drop_y", oDropped, 1'b1);

    while (k % 800 != 300) applyStimulus(1'b1, 1'b0, 8'd0, 7'd0, 3'd0);
    applyStimulus(1'b0, 1'b1, 8'd0, 7'd0, 3'd7);
    checkOutput("mid_reset_outputs", {oHS, oVS, oBlank_n, oFrameStart, oDropped, oR, oG, oB},
                {5'b11000, 24'h000000});

    for (int c = 1; c <= 36000; c++) begin
      if (c == 32041) begin
        applyStimulus(1'b1, 1'b1, 8'd10, 7'd10, 3'b010);
      end else if ($urandom_range(3) == 0) begin
        rx = 8'($urandom_range(199));
        ry = ($urandom_range(7) == 0) ? 7'(120 + $urandom_range(7)) : 7'(5 + $urandom_range(7));
        if (rx == 8'd10 && ry == 7'd10) rx = 8'd11;
        applyStimulus(1'b1, 1'b1, rx, ry, 3'($urandom));
      end else begin
        applyStimulus(1'b1, 1'b0, 8'd0, 7'd0, 3'd0);
      end
      if (c - 2 >= 800 && c - 2 < 1600) begin
        if (!oHS) hs_low++;
        if (oBlank_n) bl_high++;
      end
      case (c)
        2:     checkOutput("restart_frame_pixel00", {oFrameStart, oR, oG, oB}, {1'b1, 24'hFF0000});
        6:     checkOutput("raster_pixel_1_0", {oR, oG, oB}, 24'h0000FF);
        2405:  checkOutput("pixel00_block_corner", {oR, oG, oB}, 24'hFF0000);
        7038:  checkOutput("pixel159_2_top", {oR, oG, oB}, 24'h00FFFF);
        9441:  checkOutput("pixel159_2_corner", {oR, oG, oB}, 24'h00FFFF);
        32042: checkOutput("rdw_old_value", {oR, oG, oB}, 24'hFF0000);
        32043: checkOutput("rdw_next_read", {oR, oG, oB}, 24'h00FF00);
        32842: checkOutput("rdw_next_line", {oR, oG, oB}, 24'h00FF00);
        default: ;
      endcase
    end
    checkOutput("hs_low_per_line", hs_low, 32'd96);
    checkOutput("blank_high_per_line", bl_high, 32'd640);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
